// File: rtl/seq_div_unit.sv
// ---------------------------------------------------------------------------
// seq_div_unit
//   Multi-cycle signed divider serving the MIPS DIV instruction.
//   Dividend a comes from register A and divisor b from register B.
//   The quotient is driven on lo and the remainder on hi.
//   Division is restoring division on magnitudes, one quotient bit per clock.
//   A final cycle applies the signs.
//   A zero divisor is flagged on div_zero without running the datapath.
//
// Ports
//   clock     in   1      system clock, rising edge
//   reset     in   1      asynchronous active-low reset
//   start     in   1      one-cycle request; a/b sampled on the same edge
//   a         in   WIDTH  dividend, two's complement
//   b         in   WIDTH  divisor, two's complement
//   hi        out  WIDTH  remainder (sign of dividend), registered
//   lo        out  WIDTH  quotient (truncated toward zero), registered
//   div_zero  out  1      divisor was zero on the last accepted start
//   busy      out  1      operation in progress, through the done cycle
//   done      out  1      one-cycle pulse: hi/lo/div_zero are final
// ---------------------------------------------------------------------------
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dmag;
  logic [CNT_W-1:0] count;
  logic             sign_q;
  logic             sign_r;

  // Magnitude of a two's complement value, as an unsigned WIDTH-bit number.
  // The most-negative value maps onto itself, which is its correct magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? WIDTH'(-v) : v;
  endfunction

  // done is registered one edge after the DONE state, so busy covers that
  // cycle too; a start arriving with the done pulse is therefore ignored.
  logic accept;
  assign busy   = (state != IDLE) || done;
  assign accept = start && !busy;

  // Restoring step. The shifted partial remainder is WIDTH+1 bits wide.
  // Its top bit set means it already exceeds any WIDTH-bit divisor.
  // Otherwise the low WIDTH bits are compared directly. Either way the
  // difference is below 2^WIDTH, so WIDTH bits of it suffice.
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign ge     = rem_sh[WIDTH] || (rem_sh[WIDTH-1:0] >= dmag);
  assign diff   = rem_sh[WIDTH-1:0] - dmag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (b == '0) ? DONE : CALC;
      CALC: if (count == CNT_W'(WIDTH-1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dmag     <= '0;
      count    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            if (b == '0) begin
              div_zero <= 1'b1;
            end else begin
              div_zero <= 1'b0;
              dmag     <= mag(b);
              quo      <= mag(a);
              rem      <= '0;
              count    <= '0;
              sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r   <= a[WIDTH-1];
            end
          end
        end
        CALC: begin
          rem   <= ge ? diff : rem_sh[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ge};
          count <= count + 1'b1;
        end
        FIX: begin
          lo <= cond_neg(quo, sign_q);
          hi <= cond_neg(rem, sign_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_div_unit
//   Scoreboard bench for seq_div_unit (WIDTH = 32). The driver pushes the
//   hand-computed result of every request into a queue. A monitor pops and
//   compares on each done pulse, including the edge count since the request.
// ---------------------------------------------------------------------------
module tb_seq_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        div_zero, busy, done;

  seq_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .hi(hi), .lo(lo), .div_zero(div_zero), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sbq[$];
  int   pcnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock) pcnt = pcnt + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clock) begin
    if (reset && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
        check("div_zero", 32'(div_zero), 32'(e.dz));
        check("latency", 32'(pcnt - e.e0), 32'(e.lat));
      end
    end
  end

  // Issues one request; returns on the falling edge right after E0.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input logic edz, input int elat, input bit push);
    exp_t e;
    @(negedge clock);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    @(posedge clock);
    #1;
    if (push) begin
      e.lo = elo; e.hi = ehi; e.dz = edz; e.lat = elat; e.e0 = pcnt;
      sbq.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0BAD_F00D;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      @(negedge clock);
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic div(input logic [31:0] ta, input logic [31:0] tb_,
                     input logic [31:0] elo, input logic [31:0] ehi);
    start_op(ta, tb_, elo, ehi, 1'b0, 34, 1'b1);
    wait_idle();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    div(32'd7, 32'd2, 32'd3, 32'd1);
    // Divide by zero keeps previous hi/lo; check busy/done timing.
    start_op(32'd5, 32'd0, 32'd3, 32'd1, 1'b1, 1, 1'b1);
    check("dz_busy_e0", 32'(busy), 32'd1);
    check("dz_done_e0", 32'(done), 32'd0);
    @(negedge clock);
    check("dz_done_e1", 32'(done), 32'd1);
    check("dz_busy_e1", 32'(busy), 32'd1);
    @(negedge clock);
    check("dz_busy_e2", 32'(busy), 32'd0);
    check("dz_done_e2", 32'(done), 32'd0);
    check("dz_hold", 32'(div_zero), 32'd1);

    div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    div(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    div(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
    div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
    div(32'd0, 32'd5, 32'd0, 32'd0);

    // Second start at E10 must be ignored.
    start_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b1);
    repeat (9) @(negedge clock);
    start = 1'b1;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clock);
    start = 1'b0;
    check("busy_mid", 32'(busy), 32'd1);
    wait_idle();

    // Asynchronous reset at E15 of a divide.
    start_op(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 34, 1'b0);
    repeat (14) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_dz", 32'(div_zero), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    div(32'd9, 32'd3, 32'd3, 32'd0);
    start_op(32'd5, 32'd0, 32'd3, 32'd0, 1'b1, 1, 1'b1);
    wait_idle();

    repeat (3) @(negedge clock);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
